// File: rtl/pipeline_pkg.sv
// pipeline_pkg
// Shared definitions for the pipeline codebase slice.
//   - IMEM_ADDR_W / IMEM_DATA_W : default instruction-memory geometry
//                                 (word-address width, instruction width)
//   - loader_state_t            : state encoding of the instruction-memory loader
package pipeline_pkg;

    localparam int IMEM_ADDR_W = 8;
    localparam int IMEM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        ERR  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/imem_loader_csum.sv
// imem_loader_csum
// Running modulo-2^DATA_W sum of the program words streamed into the loader.
// Only instantiated when IMEM_LOADER_CSUM_EN is defined.
// Ports:
//   clk, rst  : clock and asynchronous active-low reset
//   clear     : synchronous clear of the running sum (new load starting)
//   add_en    : add 'data' into the sum on this edge
//   data      : word to accumulate
//   sum       : current running sum
module imem_loader_csum
    import pipeline_pkg::*;
#(
    parameter int DATA_W = IMEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              add_en,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] sum
);

    // Clear wins over add so a fresh load never inherits a stale word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (add_en) begin
            sum <= sum + data;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader
// Streams a program into instruction memory and then releases the core reset.
// Ports:
//   clk, rst                    : clock and asynchronous active-low reset
//   start                       : one-cycle pulse that begins a program load
//   s_valid, s_data, s_last     : program word stream (s_last marks final beat)
//   s_ready                     : stream accept, high only while loading
//   mem_we, mem_addr, mem_wdata : instruction-memory write port (registered)
//   core_rst                    : active-low reset for the pipeline core
//   busy, done, err             : status (loading / running / error)
// Configuration macro:
//   IMEM_LOADER_CSUM_EN : the s_last beat is a checksum over all preceding
//                         words instead of an instruction; a mismatch ends in ERR.
module imem_loader
    import pipeline_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = IMEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    loader_state_t     state;
    loader_state_t     nxt;
    logic [ADDR_W-1:0] cnt;
    logic              acc;
    logic              wr;
    logic              restart;

    // A beat is taken only while loading; s_ready mirrors state == LOAD.
    assign acc     = s_valid && (state == LOAD);
    assign restart = start && (state != LOAD);

`ifdef IMEM_LOADER_CSUM_EN
    logic [DATA_W-1:0] sum;

    // The checksum beat itself is never written nor accumulated.
    assign wr = acc && !s_last;

    imem_loader_csum #(
        .DATA_W (DATA_W)
    ) u_csum (
        .clk    (clk),
        .rst    (rst),
        .clear  (restart),
        .add_en (wr),
        .data   (s_data),
        .sum    (sum)
    );
`else
    assign wr = acc;
`endif

    // Next-state decision. A last beat finishes the load even at the top
    // address; only a non-last beat at the top address overflows to ERR.
    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (start) nxt = LOAD;
            end
            LOAD: begin
                if (acc) begin
                    if (s_last) begin
`ifdef IMEM_LOADER_CSUM_EN
                        nxt = (s_data == sum) ? RUN : ERR;
`else
                        nxt = RUN;
`endif
                    end else if (cnt == LAST_ADDR) begin
                        nxt = ERR;
                    end
                end
            end
            RUN, ERR: begin
                if (start) nxt = LOAD;
            end
            default: nxt = IDLE;
        endcase
    end

    // State, counter and all outputs are registered together. done/core_rst
    // are held low for the cycle in which the final word is still being
    // written, so the core only leaves reset once memory is complete.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            s_ready   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            core_rst  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state    <= nxt;
            s_ready  <= (nxt == LOAD);
            busy     <= (nxt == LOAD);
            done     <= (nxt == RUN) && !wr;
            core_rst <= (nxt == RUN) && !wr;
            err      <= (nxt == ERR);
            mem_we   <= wr;
            if (wr) begin
                mem_addr  <= cnt;
                mem_wdata <= s_data;
            end
            // Counter saturates at the top address instead of wrapping.
            if (restart) begin
                cnt <= '0;
            end else if (acc && (cnt != LAST_ADDR)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// Scoreboard bench for imem_loader (ADDR_W=2 so the overflow boundary is
// reachable). Works with and without IMEM_LOADER_CSUM_EN.
module tb_imem_loader;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef IMEM_LOADER_CSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              s_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              core_rst;
    logic              busy;
    logic              done;
    logic              err;

    always #5 clk = ~clk;

    imem_loader #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .core_rst  (core_rst),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          stamp;
    } wr_t;

    wr_t expq[$];

    // Behavioural model: load in progress, words written so far, running sum,
    // outcome (0 none, 1 running, 2 error) and whether the final beat was written.
    bit          m_loading = 1'b0;
    int          m_count   = 0;
    logic [31:0] m_sum     = '0;
    int          m_result  = 0;
    bit          m_last_wrote = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every write the DUT presents must match the next expected one.
    always @(negedge clk) begin
        if (rst === 1'b1 && mem_we === 1'b1) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write: addr=%0d data=0x%0h, expected no write",
                         mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = expq.pop_front();
                checkOutput("write_addr", 64'(mem_addr), 64'(e.addr));
                checkOutput("write_data", 64'(mem_wdata), 64'(e.data));
                checkOutput("write_cycle", 64'(cyc), 64'(e.stamp));
            end
        end
    end

    task automatic checkResetValues();
        checkOutput("rst_s_ready", 64'(s_ready), 64'd0);
        checkOutput("rst_mem_we", 64'(mem_we), 64'd0);
        checkOutput("rst_mem_addr", 64'(mem_addr), 64'd0);
        checkOutput("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        checkOutput("rst_core_rst", 64'(core_rst), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_err", 64'(err), 64'd0);
    endtask

    task automatic checkStatus(input string tag);
        #1;
        checkOutput({tag, "_s_ready"}, 64'(s_ready), 64'(m_loading));
        checkOutput({tag, "_busy"}, 64'(busy), 64'(m_loading));
        checkOutput({tag, "_done"}, 64'(done), 64'(m_result == 1));
        checkOutput({tag, "_core_rst"}, 64'(core_rst), 64'(m_result == 1));
        checkOutput({tag, "_err"}, 64'(err), 64'(m_result == 2));
        checkOutput({tag, "_pending"}, 64'(expq.size()), 64'd0);
    endtask

    // Called at a negedge; start is sampled on the following rising edge.
    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (!m_loading) begin
            m_loading = 1'b1;
            m_count   = 0;
            m_sum     = '0;
            m_result  = 0;
        end
    endtask

    // Optional idle gap (with an optional ignored start pulse), then one beat.
    task automatic applyStimulus(input logic [31:0] data, input bit last,
                                 input int gap, input bit poke);
        wr_t e;
        for (int g = 0; g < gap; g++) begin
            start = (poke && g == 0);
            @(negedge clk);
            start = 1'b0;
            checkOutput("gap_mem_we", 64'(mem_we), 64'd0);
        end
        checkOutput("beat_s_ready", 64'(s_ready), 64'(m_loading));
        if (m_loading) begin
            s_valid = 1'b1;
            s_data  = data;
            s_last  = last;
            m_last_wrote = !(CSUM && last);
            if (m_last_wrote) begin
                e.addr  = m_count;
                e.data  = data;
                e.stamp = cyc + 1;
                expq.push_back(e);
            end
            if (CSUM && last) begin
                m_result  = (data == m_sum) ? 1 : 2;
                m_loading = 1'b0;
            end else begin
                m_sum = m_sum + data;
                if (last) begin
                    m_result  = 1;
                    m_loading = 1'b0;
                end else if (m_count == DEPTH - 1) begin
                    m_result  = 2;
                    m_loading = 1'b0;
                end else begin
                    m_count++;
                end
            end
            @(negedge clk);
            s_valid = 1'b0;
            s_last  = 1'b0;
            s_data  = $urandom;
        end
    endtask

    // In the cycle right after the final accept the core must still be held
    // in reset if that beat is being written; one cycle later status settles.
    task automatic finishLoad(input string tag);
        #1;
        checkOutput({tag, "_core_rst_final_cycle"}, 64'(core_rst),
                    64'((m_result == 1) && !m_last_wrote));
        @(negedge clk);
        checkStatus(tag);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int len;
        logic [31:0] w;

        rst     = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        #2 rst = 1'b0;
        #1 checkResetValues();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] basic load");
        pulseStart();
        checkStatus("basic_start");
        applyStimulus(32'h00500093, 1'b0, 0, 1'b0);
        applyStimulus(32'h00300113, 1'b0, 0, 1'b0);
        applyStimulus(32'h002081B3, 1'b1, 0, 1'b0);
        finishLoad("basic");

        $display("[TB] reload from finished state");
        pulseStart();
        checkStatus("reload_start");
        applyStimulus(32'hDEADBEEF, 1'b1, 0, 1'b0);
        finishLoad("reload");

        $display("[TB] backpressure gap");
        pulseStart();
        applyStimulus(32'h11111111, 1'b0, 0, 1'b0);
        applyStimulus(32'h22222222, 1'b0, 5, 1'b1);
        applyStimulus(32'h33333333, 1'b1, 0, 1'b0);
        finishLoad("gap");

        $display("[TB] overflow");
        pulseStart();
        for (int i = 0; i < DEPTH; i++) applyStimulus(32'hA0 + i, 1'b0, 0, 1'b0);
        finishLoad("overflow");

        $display("[TB] checksum words");
        pulseStart();
        applyStimulus(32'h1, 1'b0, 0, 1'b0);
        applyStimulus(32'h2, 1'b0, 0, 1'b0);
        applyStimulus(32'h3, 1'b1, 0, 1'b0);
        finishLoad("csum_good");
        pulseStart();
        applyStimulus(32'h1, 1'b0, 0, 1'b0);
        applyStimulus(32'h2, 1'b0, 0, 1'b0);
        applyStimulus(32'h4, 1'b1, 0, 1'b0);
        finishLoad("csum_bad");

        $display("[TB] reset mid-load");
        pulseStart();
        applyStimulus($urandom, 1'b0, 0, 1'b0);
        applyStimulus($urandom, 1'b0, 0, 1'b0);
        #2 rst = 1'b0;
        m_loading = 1'b0;
        m_result  = 0;
        #1 checkResetValues();
        s_valid = 1'b1;
        s_data  = $urandom;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #1;
            checkOutput("post_rst_mem_we", 64'(mem_we), 64'd0);
            checkOutput("post_rst_s_ready", 64'(s_ready), 64'd0);
        end
        s_valid = 1'b0;
        @(negedge clk);
        pulseStart();
        applyStimulus(32'h0BADF00D, 1'b1, 0, 1'b0);
        finishLoad("after_rst");

        $display("[TB] random loads");
        for (int n = 0; n < 30; n++) begin
            pulseStart();
            len = $urandom_range(1, DEPTH + 1);
            for (int i = 0; i < len && m_loading; i++) begin
                w = $urandom;
                if (i == len - 1 && ($urandom % 2) == 1) w = m_sum;
                applyStimulus(w, (i == len - 1), $urandom_range(0, 3),
                              ($urandom % 4) == 0);
            end
            finishLoad("rand");
        end

        repeat (3) @(negedge clk);
        checkOutput("pending_writes_end", 64'(expq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 8, meaning the instruction-memory word-address width (depth 2^ADDR_W words).
REQ-002 The module SHALL have parameter DATA_W, default 32, meaning the instruction word width.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port start, input, 1 bit: a one-cycle pulse that begins a program load.
REQ-006 The module SHALL have ports s_valid (input, 1), s_data (input, DATA_W) and s_last (input, 1): the program word stream, with s_last marking the final beat.
REQ-007 The module SHALL have port s_ready, output, 1 bit: stream accept.
REQ-008 The module SHALL have ports mem_we (output, 1), mem_addr (output, ADDR_W) and mem_wdata (output, DATA_W): the instruction-memory write port.
REQ-009 The module SHALL have port core_rst, output, 1 bit: the active-low reset driven to the pipeline core.
REQ-010 The module SHALL have ports busy (output, 1), done (output, 1) and err (output, 1): status.

Function
REQ-011 The FSM SHALL have exactly the states IDLE, LOAD, RUN and ERR.
REQ-012 In IDLE, start SHALL move the FSM to LOAD on the next edge and clear the word counter to 0.
REQ-013 In LOAD, s_ready SHALL be 1; in all other states s_ready SHALL be 0.
REQ-014 A beat SHALL be accepted only when s_valid and s_ready are both 1 on the same edge; s_data SHALL not be sampled otherwise.
REQ-015 One cycle after an accepted beat, the outputs SHALL be mem_we=1, mem_addr=counter value at acceptance and mem_wdata=the accepted s_data; mem_we SHALL be 0 in every other cycle.
REQ-016 The counter SHALL increment by 1 per accepted beat.
REQ-017 An accepted beat with s_last=1 SHALL move the FSM to RUN, unless REQ-019 or REQ-026 applies.
REQ-018 In RUN, core_rst SHALL be 1 starting the cycle after the final mem_we; core_rst SHALL be 0 in every other state, so the core never runs on a partly written memory.
REQ-019 Accepting a beat with s_last=0 when the counter equals 2^ADDR_W-1 (memory full) SHALL write that word and then move the FSM to ERR; the counter SHALL NOT wrap.
REQ-020 A start pulse in LOAD SHALL be ignored; a start pulse in RUN or ERR SHALL re-enter LOAD with counter 0, and core_rst SHALL fall on that same edge.
REQ-021 busy SHALL be 1 exactly in LOAD; done SHALL be 1 exactly in RUN; err SHALL be 1 exactly in ERR.
REQ-022 s_valid deasserted mid-load SHALL stall the FSM in LOAD indefinitely with no writes and no timeout.

Reset
REQ-023 While rst=0, the outputs SHALL immediately be: FSM in IDLE, counter=0, s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_rst=0, busy=0, done=0 and err=0.
REQ-024 Reset asserted mid-load SHALL abandon the load with no further writes; the loader SHALL NOT resume after reset is released.

Configuration
REQ-025 When the macro IMEM_LOADER_CSUM_EN is defined, the final (s_last) beat SHALL be a checksum word, not an instruction: it SHALL NOT be written to memory (no mem_we for it).
REQ-026 When IMEM_LOADER_CSUM_EN is defined, the checksum word SHALL be compared against the DATA_W-bit modulo-2^DATA_W sum of all preceding accepted words; on a match the FSM SHALL go to RUN, on a mismatch to ERR.
REQ-027 When IMEM_LOADER_CSUM_EN is undefined, the s_last beat SHALL be an ordinary instruction word and no accumulator logic SHALL exist.

Structure
REQ-028 The FSM state encoding and the default ADDR_W and DATA_W constants SHALL live in the shared package pipeline_pkg.
REQ-029 The checksum accumulator SHALL be a sub-module imem_loader_csum (clear, add-enable, sum output), instantiated only under IMEM_LOADER_CSUM_EN.

Verification
REQ-030 The bench SHALL cover basic load: start, then 3 beats 0x00500093, 0x00300113, 0x002081B3 with last on the 3rd -> writes to addr 0,1,2 with those words; core_rst=1 and done=1 from the cycle after the 3rd write.
REQ-031 The bench SHALL cover backpressure gaps: s_valid low for 5 cycles between beats 1 and 2 -> no mem_we during the gap, and addresses stay contiguous 0,1,2.
REQ-032 The bench SHALL cover overflow: ADDR_W=2, 4 beats with s_last=0 -> addr 0..3 written, then err=1, s_ready=0 and core_rst=0.
REQ-033 The bench SHALL cover reset mid-load: rst low after 2 of 5 beats -> all outputs at reset values immediately; after rst is released, no write occurs until a new start.
REQ-034 The bench SHALL cover reload from RUN: start pulse while done=1 -> core_rst=0 on that edge and the counter restarts at addr 0.
REQ-035 The bench SHALL cover the checksum (IMEM_LOADER_CSUM_EN): words 0x1 and 0x2 followed by last word 0x3 -> RUN with 2 writes; last word 0x4 -> err=1.
